// File: rtl/mem_inspector_pkg.sv
// Shared types and constants for the memory inspector.
// Auto-refresh variant is enabled with MEM_INSPECTOR_AUTOREFRESH_EN.
package mem_inspector_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    localparam int DEF_SCAN_DIV        = 1024;
    localparam int DEF_REFRESH_CYCLES  = 1 << 20;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} rd_state_e;

    // Active-low {dp,g..a}, dp off, indexed by hex value
    localparam logic [15:0][7:0] SEG_TBL = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex2seg(logic [3:0] h, logic dp);
        return {dp, SEG_TBL[h][6:0]};
    endfunction

endpackage

// File: rtl/mem_inspector_if.sv
// Memory read port between the inspector (master) and a memory (slave).
// Auto-refresh option (MEM_INSPECTOR_AUTOREFRESH_EN) does not change it.
interface mem_inspector_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output mem_addr,
        output mem_req,
        output busy,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        input  busy,
        output mem_rdata
    );
endinterface

// File: rtl/mem_inspector_btn_debounce.sv
// Button synchroniser, stable-level filter and rising-edge press pulse.
// Unaffected by MEM_INSPECTOR_AUTOREFRESH_EN.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0_q;
    logic          sync1_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= btn_i;
            sync1_q <= sync0_q;
            press_q <= 1'b0;
            if (sync1_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Nth consecutive differing sample: accept new level
                cnt_q   <= '0;
                level_q <= sync1_q;
                press_q <= sync1_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mem_inspector.sv
// Debug display controller: steps an address, reads memory, shows hex on 7-seg.
// Define MEM_INSPECTOR_AUTOREFRESH_EN for periodic re-reads (REFRESH_CYCLES).
module mem_inspector
    import mem_inspector_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 32,
    parameter int NUM_DIGITS      = 4,
    parameter int ADDR_STEP       = 4,
    parameter int RD_LAT          = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SCAN_DIV        = DEF_SCAN_DIV
`ifdef MEM_INSPECTOR_AUTOREFRESH_EN
    , parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_inc_i,
    input  logic                  btn_dec_i,
    input  logic                  show_addr_i,
    mem_inspector_if.master       mem,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [7:0]            seg_o
);
    localparam int PW = $clog2(SCAN_DIV + 1);

    logic              inc_p;
    logic              dec_p;
    logic              chg;
    logic              refresh;
    logic              launch;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] data_q;
    logic              pending_q;
    logic              mem_req_q;
    logic              busy_q;
    logic [2:0]        wcnt_q;
    rd_state_e         state_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .reset(reset), .btn_i(btn_inc_i), .press_o(inc_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .reset(reset), .btn_i(btn_dec_i), .press_o(dec_p)
    );

    // Opposing presses in the same cycle cancel out
    assign chg = inc_p ^ dec_p;

    always_comb begin
        addr_d = addr_q;
        if (inc_p && !dec_p)
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
        else if (dec_p && !inc_p)
            addr_d = addr_q - ADDR_W'(ADDR_STEP);
    end

`ifdef MEM_INSPECTOR_AUTOREFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    logic [RW-1:0] rcnt_q;

    assign refresh = (rcnt_q == RW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || chg || refresh)
            rcnt_q <= '0;
        else
            rcnt_q <= rcnt_q + 1'b1;
    end
`else
    assign refresh = 1'b0;
`endif

    assign launch = (state_q == IDLE) && pending_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            data_q     <= '0;
            pending_q  <= 1'b1;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            mem_req_q <= 1'b0;
            pending_q <= (pending_q && !launch) || chg || refresh;
            unique case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        mem_addr_q <= addr_q;
                    end
                end
                REQ: begin
                    wcnt_q <= '0;
                    if (RD_LAT > 1)
                        state_q <= WAIT;
                    else
                        state_q <= CAPTURE;
                end
                WAIT: begin
                    if (wcnt_q == 3'(RD_LAT - 2))
                        state_q <= CAPTURE;
                    else
                        wcnt_q <= wcnt_q + 1'b1;
                end
                CAPTURE: begin
                    data_q  <= mem.mem_rdata;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.busy     = busy_q;

    logic [PW-1:0]         psc_q;
    logic [2:0]            idx_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            seg_q;
    logic [63:0]           src;
    logic [3:0]            nib;
    logic                  dp;

    always_comb begin
        src = show_addr_i ? 64'(mem_addr_q) : 64'(data_q);
        nib = src[{idx_q, 2'b00} +: 4];
        dp  = !(((idx_q == 3'd0) && busy_q) ||
                ((idx_q == 3'(NUM_DIGITS - 1)) && show_addr_i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= ~(NUM_DIGITS'(1) << idx_q);
            seg_q <= hex2seg(nib, dp);
            if (psc_q == PW'(SCAN_DIV - 1)) begin
                psc_q <= '0;
                if (idx_q == 3'(NUM_DIGITS - 1))
                    idx_q <= 3'd0;
                else
                    idx_q <= idx_q + 3'd1;
            end else begin
                psc_q <= psc_q + 1'b1;
            end
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: tb/tb_mem_inspector.sv
// Directed bench for mem_inspector (RD_LAT=1 and RD_LAT=3 instances).
// With MEM_INSPECTOR_AUTOREFRESH_EN a third instance checks periodic reads.
module tb_mem_inspector;
    import mem_inspector_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic inc = 1'b0, dec = 1'b0, show = 1'b0;
    logic inc3 = 1'b0, dec3 = 1'b0;
    logic [3:0] an, an3;
    logic [7:0] seg, seg3;
    int errors = 0;
    int checks = 0;

    mem_inspector_if #(.ADDR_W(16), .DATA_W(32)) mif ();
    mem_inspector_if #(.ADDR_W(16), .DATA_W(32)) mif3 ();

    mem_inspector #(
        .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .btn_inc_i(inc), .btn_dec_i(dec),
        .show_addr_i(show), .mem(mif), .an_o(an), .seg_o(seg)
    );

    mem_inspector #(
        .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .RD_LAT(3)
    ) dut3 (
        .clk(clk), .reset(reset), .btn_inc_i(inc3), .btn_dec_i(dec3),
        .show_addr_i(1'b0), .mem(mif3), .an_o(an3), .seg_o(seg3)
    );

    function automatic logic [31:0] mem_word(logic [15:0] a);
        return {a, a ^ 16'h1234};
    endfunction

    // Memory models: data valid only in the cycle RD_LAT after mem_req
    logic v1 = 1'b0;
    logic [15:0] a1 = '0;
    always @(posedge clk) begin
        v1 <= mif.mem_req;
        a1 <= mif.mem_addr;
    end
    assign mif.mem_rdata = v1 ? mem_word(a1) : 32'hDEAD_BEEF;

    logic [2:0] v3 = '0;
    logic [15:0] a3 [3];
    always @(posedge clk) begin
        v3 <= {v3[1:0], mif3.mem_req};
        a3[0] <= mif3.mem_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign mif3.mem_rdata = v3[2] ? mem_word(a3[2]) : 32'hDEAD_BEEF;

    int req_cnt = 0;
    int dbl_req = 0;
    logic prev_req = 1'b0, prev_req3 = 1'b0;
    logic [15:0] last_addr = '0;
    always @(posedge clk) begin
        if (mif.mem_req) begin
            req_cnt++;
            last_addr = mif.mem_addr;
        end
        if (mif.mem_req && prev_req) dbl_req++;
        if (mif3.mem_req && prev_req3) dbl_req++;
        prev_req = mif.mem_req;
        prev_req3 = mif3.mem_req;
    end

`ifdef MEM_INSPECTOR_AUTOREFRESH_EN
    mem_inspector_if #(.ADDR_W(16), .DATA_W(32)) mifr ();
    logic [3:0] anr;
    logic [7:0] segr;
    int reqr_cnt = 0;
    logic addr_moved = 1'b0;
    mem_inspector #(
        .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .RD_LAT(1), .REFRESH_CYCLES(16)
    ) dutr (
        .clk(clk), .reset(reset), .btn_inc_i(1'b0), .btn_dec_i(1'b0),
        .show_addr_i(1'b0), .mem(mifr), .an_o(anr), .seg_o(segr)
    );
    assign mifr.mem_rdata = 32'h0000_5A5A;
    always @(posedge clk) begin
        if (mifr.mem_req) reqr_cnt++;
        if (mifr.mem_req && mifr.mem_addr !== 16'h0) addr_moved = 1'b1;
    end
`endif

    task automatic scan(input int sel, output logic [3:0][7:0] s);
        logic [3:0] m;
        s = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                m = ~(4'b0001 << d);
                if (sel == 0 && an === m) s[d] = seg;
                if (sel == 1 && an3 === m) s[d] = seg3;
            end
        end
    endtask

    task automatic press(input int which);
        if (which == 0) inc = 1'b1;
        else dec = 1'b1;
        repeat (10) @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0][7:0] s;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mif.mem_req !== 1'b0 || mif.busy !== 1'b0)
            $display("FAIL reset_req_busy: got req=%b busy=%b want 0 0",
                     mif.mem_req, mif.busy);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF)
            $display("FAIL reset_display: got an=%h seg=%h want F FF", an, seg);
        if (an !== 4'hF || seg !== 8'hFF) errors++;
        if (mif.mem_req !== 1'b0 || mif.busy !== 1'b0) errors++;
        checks++;
        if (mif.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0000", mif.mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mif.mem_req !== 1'b1 || mif.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h want 1 0000",
                     mif.mem_req, mif.mem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL first_busy: got %b want 0", mif.busy);
        end
        scan(0, s);
        checks++;
        if (s !== {8'hF9, 8'hA4, 8'hB0, 8'h99}) begin
            errors++;
            $display("FAIL first_data_digits: got %h want f9a4b099", s);
        end
    endtask

    task automatic test_inc_hold();
        logic [3:0][7:0] s;
        int base;
        base = req_cnt;
        inc = 1'b1;
        repeat (20) @(negedge clk);
        inc = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (req_cnt - base != 1 || last_addr !== 16'h4) begin
            errors++;
            $display("FAIL inc_hold: got reqs=%0d addr=%h want 1 0004",
                     req_cnt - base, last_addr);
        end
        scan(0, s);
        checks++;
        if (s !== {8'hF9, 8'hA4, 8'hB0, 8'hC0}) begin
            errors++;
            $display("FAIL inc_data_digits: got %h want f9a4b0c0", s);
        end
    endtask

    task automatic test_glitch();
        int base;
        base = req_cnt;
        dec = 1'b1;
        repeat (3) @(negedge clk);
        dec = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (req_cnt != base || mif.mem_addr !== 16'h4) begin
            errors++;
            $display("FAIL glitch: got reqs=%0d addr=%h want 0 0004",
                     req_cnt - base, mif.mem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [3:0][7:0] s;
        press(1);
        checks++;
        if (mif.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL dec_to_zero: got %h want 0000", mif.mem_addr);
        end
        press(1);
        checks++;
        if (mif.mem_addr !== 16'hFFFC) begin
            errors++;
            $display("FAIL dec_wrap: got %h want fffc", mif.mem_addr);
        end
        scan(0, s);
        checks++;
        if (s !== {8'h86, 8'hA1, 8'hC6, 8'h80}) begin
            errors++;
            $display("FAIL wrap_data_digits: got %h want 86a1c680", s);
        end
        press(0);
        checks++;
        if (mif.mem_addr !== 16'h0 || last_addr !== 16'h0) begin
            errors++;
            $display("FAIL inc_wrap: got %h want 0000", mif.mem_addr);
        end
    endtask

    task automatic test_simul();
        int base;
        base = req_cnt;
        inc = 1'b1;
        dec = 1'b1;
        repeat (10) @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (req_cnt != base || mif.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL simultaneous: got reqs=%0d addr=%h want 0 0000",
                     req_cnt - base, mif.mem_addr);
        end
    endtask

    task automatic test_show_addr();
        logic [3:0][7:0] s;
        repeat (65) press(0);
        checks++;
        if (mif.mem_addr !== 16'h0104) begin
            errors++;
            $display("FAIL addr_0104: got %h want 0104", mif.mem_addr);
        end
        show = 1'b1;
        scan(0, s);
        show = 1'b0;
        checks++;
        if (s !== {8'h40, 8'hF9, 8'hC0, 8'h99}) begin
            errors++;
            $display("FAIL show_addr_digits: got %h want 40f9c099", s);
        end
    endtask

    task automatic test_rd_lat3();
        logic r [30];
        logic b [30];
        logic [15:0] ad [30];
        logic [3:0][7:0] s;
        int r1, r2, nreq, blow, bad_addr;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) dec3 = 1'b1;
            if (i == 3) inc3 = 1'b1;
            if (i == 15) dec3 = 1'b0;
            if (i == 18) inc3 = 1'b0;
            r[i] = mif3.mem_req;
            b[i] = mif3.busy;
            ad[i] = mif3.mem_addr;
        end
        r1 = -1;
        r2 = -1;
        nreq = 0;
        for (int i = 0; i < 30; i++) begin
            if (r[i] === 1'b1) begin
                nreq++;
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        checks++;
        if (nreq != 2 || r1 < 0 || r2 < 0) begin
            errors++;
            $display("FAIL lat3_req_count: got %0d want 2", nreq);
        end else begin
            blow = 0;
            bad_addr = 0;
            for (int i = r1; i <= r2; i++) if (b[i] !== 1'b1) blow++;
            for (int i = r1; i < r2; i++) if (ad[i] !== 16'hFFFC) bad_addr++;
            checks++;
            if (r2 - r1 != 5) begin
                errors++;
                $display("FAIL lat3_gap: got %0d want 5", r2 - r1);
            end
            checks++;
            if (ad[r2] !== 16'h0 || bad_addr != 0) begin
                errors++;
                $display("FAIL lat3_addrs: got bad=%0d second=%h want 0 0000",
                         bad_addr, ad[r2]);
            end
            checks++;
            if (blow != 1) begin
                errors++;
                $display("FAIL lat3_busy: got %0d idle cycles want 1", blow);
            end
        end
        scan(1, s);
        checks++;
        if (s !== {8'hF9, 8'hA4, 8'hB0, 8'h99}) begin
            errors++;
            $display("FAIL lat3_data_digits: got %h want f9a4b099", s);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        inc3 = 1'b1;
        while (mif3.mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL midreset_timeout: got no req want req");
        end
        @(negedge clk);
        inc3 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mif3.mem_req !== 1'b0 || mif3.busy !== 1'b0 || an3 !== 4'hF) begin
            errors++;
            $display("FAIL midreset: got req=%b busy=%b an=%h want 0 0 f",
                     mif3.mem_req, mif3.busy, an3);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mif3.mem_req !== 1'b1 || mif3.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL midreset_restart: got req=%b addr=%h want 1 0000",
                     mif3.mem_req, mif3.mem_addr);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_idle_reads();
        int base;
        repeat (20) @(negedge clk);
        base = req_cnt;
`ifdef MEM_INSPECTOR_AUTOREFRESH_EN
        begin
            int rb;
            rb = reqr_cnt;
            repeat (64) @(negedge clk);
            checks++;
            if (reqr_cnt - rb != 4 || addr_moved) begin
                errors++;
                $display("FAIL autorefresh: got %0d reqs moved=%b want 4 0",
                         reqr_cnt - rb, addr_moved);
            end
        end
`else
        repeat (64) @(negedge clk);
`endif
        checks++;
        if (req_cnt != base) begin
            errors++;
            $display("FAIL idle_no_reads: got %0d want 0", req_cnt - base);
        end
        checks++;
        if (dbl_req != 0) begin
            errors++;
            $display("FAIL back_to_back_req: got %0d want 0", dbl_req);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_inc_hold();
        test_glitch();
        test_wrap();
        test_simul();
        test_show_addr();
        test_rd_lat3();
        test_reset_mid();
        test_idle_reads();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
